// File: rtl/alu_pkg.sv
// Shared decode definitions: ALU operation codes, MIPS opcode/funct values,
// and the ID/EX control word with its bubble value.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_ADD   = 4'd2,
        ALU_SLL   = 4'd3,
        ALU_SRL   = 4'd4,
        ALU_EQ    = 4'd5,
        ALU_SUB   = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_LUI   = 4'd8,
        ALU_LINK  = 4'd9,
        ALU_NOR   = 4'd12,
        ALU_XOR   = 4'd13,
        ALU_PASSA = 4'd14
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic      valid;
        alu_ctrl_e alu_ctrl;
        logic      alu_src_imm;
        logic      reg_write;
        logic      illegal;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '{
        valid:       1'b0,
        alu_ctrl:    ALU_ADD,
        alu_src_imm: 1'b0,
        reg_write:   1'b0,
        illegal:     1'b0
    };

endpackage

// File: rtl/d_alu_ctrl_dec.sv
// Combinational MIPS instruction decode into ID/EX control, immediate,
// shift amount and writeback destination.
module d_alu_ctrl_dec
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic [DATA_W-1:0] instr,
    output idex_ctrl_t        ctrl,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] imm,
    output logic [REG_AW-1:0] dst
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic              unused_rs;

    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign rt        = instr[16 +: REG_AW];
    assign rd        = instr[11 +: REG_AW];
    assign shamt     = instr[10:6];
    assign imm_sext  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, instr[15:0]};
    assign unused_rs = ^instr[25:21];

    // Unknown encodings keep the ADD/no-write defaults and only raise illegal.
    always_comb begin
        ctrl       = IDEX_BUBBLE;
        ctrl.valid = 1'b1;
        imm        = imm_sext;
        dst        = rt;
        case (op)
            OP_RTYPE: begin
                dst            = rd;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:          ctrl.alu_ctrl = ALU_AND;
                    FN_OR:           ctrl.alu_ctrl = ALU_OR;
                    FN_XOR:          ctrl.alu_ctrl = ALU_XOR;
                    FN_NOR:          ctrl.alu_ctrl = ALU_NOR;
                    FN_SLT, FN_SLTU: ctrl.alu_ctrl = ALU_SLT;
                    FN_SLL:          ctrl.alu_ctrl = ALU_SLL;
                    FN_SRL:          ctrl.alu_ctrl = ALU_SRL;
                    FN_JR: begin
                        ctrl.alu_ctrl  = ALU_PASSA;
                        ctrl.reg_write = 1'b0;
                    end
                    default: begin
                        ctrl.illegal   = 1'b1;
                        ctrl.reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                case (op)
                    OP_SLTI, OP_SLTIU: ctrl.alu_ctrl = ALU_SLT;
                    OP_ANDI: begin ctrl.alu_ctrl = ALU_AND; imm = imm_zext; end
                    OP_ORI:  begin ctrl.alu_ctrl = ALU_OR;  imm = imm_zext; end
                    OP_XORI: begin ctrl.alu_ctrl = ALU_XOR; imm = imm_zext; end
                    OP_LUI:  begin ctrl.alu_ctrl = ALU_LUI; imm = imm_zext; end
                    default: ctrl.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_SW:  ctrl.alu_src_imm = 1'b1;
            OP_BEQ: ctrl.alu_ctrl    = ALU_SUB;
            OP_BNE: ctrl.alu_ctrl    = ALU_EQ;
            OP_J:   ctrl.alu_ctrl    = ALU_ADD;
            OP_JAL: begin
                ctrl.alu_ctrl  = ALU_LINK;
                ctrl.reg_write = 1'b1;
                dst            = REG_AW'(LINK_REG);
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/d_alu_decode.sv
// ID/EX pipeline register around the ALU control decoder; one-cycle latency.
// Priority per edge: reset, then flush (bubble), then stall (hold), then load.
module d_alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data_Instr,
    input  logic              i_con_Valid,
    input  logic              i_con_Stall,
    input  logic              i_con_Flush,
    output logic              o_con_Valid,
    output logic [3:0]        o_con_AluCtrl,
    output logic [4:0]        o_data_shamt,
    output logic [DATA_W-1:0] o_data_Imm,
    output logic              o_con_AluSrcImm,
    output logic              o_con_RegWrite,
    output logic [REG_AW-1:0] o_data_Dst,
    output logic              o_con_Illegal
);

    idex_ctrl_t        dec_ctrl;
    logic [4:0]        dec_shamt;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_dst;

    idex_ctrl_t        ctrl_q;
    logic [4:0]        shamt_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] dst_q;

    d_alu_ctrl_dec #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_dec (
        .instr (i_data_Instr),
        .ctrl  (dec_ctrl),
        .shamt (dec_shamt),
        .imm   (dec_imm),
        .dst   (dec_dst)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || i_con_Flush || (!i_con_Stall && !i_con_Valid)) begin
            ctrl_q  <= IDEX_BUBBLE;
            shamt_q <= '0;
            imm_q   <= '0;
            dst_q   <= '0;
        end else if (!i_con_Stall) begin
            ctrl_q  <= dec_ctrl;
            shamt_q <= dec_shamt;
            imm_q   <= dec_imm;
            dst_q   <= dec_dst;
        end
    end

    assign o_con_Valid     = ctrl_q.valid;
    assign o_con_AluCtrl   = ctrl_q.alu_ctrl;
    assign o_con_AluSrcImm = ctrl_q.alu_src_imm;
    assign o_con_RegWrite  = ctrl_q.reg_write;
    assign o_con_Illegal   = ctrl_q.illegal;
    assign o_data_shamt    = shamt_q;
    assign o_data_Imm      = imm_q;
    assign o_data_Dst      = dst_q;

endmodule

// File: tb/tb_d_alu_decode.sv
// Directed-vector bench for d_alu_decode with hand-computed expectations.
module tb_d_alu_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        vld_in;
    logic        stall;
    logic        flush;
    logic        vld;
    logic [3:0]  alu_ctrl;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        src_imm;
    logic        reg_write;
    logic [4:0]  dst;
    logic        illegal;

    int total = 0;
    int passed = 0;

    d_alu_decode dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_data_Instr    (instr),
        .i_con_Valid     (vld_in),
        .i_con_Stall     (stall),
        .i_con_Flush     (flush),
        .o_con_Valid     (vld),
        .o_con_AluCtrl   (alu_ctrl),
        .o_data_shamt    (shamt),
        .o_data_Imm      (imm),
        .o_con_AluSrcImm (src_imm),
        .o_con_RegWrite  (reg_write),
        .o_data_Dst      (dst),
        .o_con_Illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one valid instruction with no stall/flush and wait for it to register.
    task automatic issue(input logic [31:0] ins);
        instr  = ins;
        vld_in = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = '0; vld_in = 1'b0; stall = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        total++;
        if ({vld, alu_ctrl, shamt, imm, src_imm, reg_write, dst, illegal} !==
            {1'b0, 4'd2, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0})
            $display("FAIL reset: got v=%b ctl=%0d sh=%0d imm=%h src=%b rw=%b dst=%0d ill=%b, need 0,2,0,0,0,0,0,0",
                     vld, alu_ctrl, shamt, imm, src_imm, reg_write, dst, illegal);
        else passed++;
    endtask

    task automatic test_rtype();
        issue(32'h00221820);  // add $3,$1,$2
        total++;
        if ({vld, alu_ctrl, src_imm, reg_write, dst, illegal} !== {1'b1, 4'd2, 1'b0, 1'b1, 5'd3, 1'b0})
            $display("FAIL add: got v=%b ctl=%0d src=%b rw=%b dst=%0d, need 1,2,0,1,3", vld, alu_ctrl, src_imm, reg_write, dst);
        else passed++;

        issue(32'h000521C0);  // sll $4,$5,7
        total++;
        if ({alu_ctrl, shamt, dst, reg_write} !== {4'd3, 5'd7, 5'd4, 1'b1})
            $display("FAIL sll: got ctl=%0d sh=%0d dst=%0d rw=%b, need 3,7,4,1", alu_ctrl, shamt, dst, reg_write);
        else passed++;

        issue(32'h00432022);  // sub $4,$2,$3
        total++;
        if ({alu_ctrl, dst} !== {4'd6, 5'd4})
            $display("FAIL sub: got ctl=%0d dst=%0d, need 6,4", alu_ctrl, dst);
        else passed++;

        issue(32'h03E00008);  // jr $31
        total++;
        if ({alu_ctrl, reg_write, illegal} !== {4'd14, 1'b0, 1'b0})
            $display("FAIL jr: got ctl=%0d rw=%b ill=%b, need 14,0,0", alu_ctrl, reg_write, illegal);
        else passed++;
    endtask

    task automatic test_itype();
        issue(32'h3422FFFF);  // ori $2,$1,0xFFFF
        total++;
        if ({alu_ctrl, imm, dst, src_imm, reg_write} !== {4'd1, 32'h0000FFFF, 5'd2, 1'b1, 1'b1})
            $display("FAIL ori: got ctl=%0d imm=%h dst=%0d src=%b rw=%b, need 1,0000ffff,2,1,1", alu_ctrl, imm, dst, src_imm, reg_write);
        else passed++;

        issue(32'h2022FFFF);  // addi $2,$1,-1
        total++;
        if ({alu_ctrl, imm, src_imm} !== {4'd2, 32'hFFFFFFFF, 1'b1})
            $display("FAIL addi: got ctl=%0d imm=%h src=%b, need 2,ffffffff,1", alu_ctrl, imm, src_imm);
        else passed++;

        issue(32'h3C018234);  // lui $1,0x8234
        total++;
        if ({alu_ctrl, imm, dst} !== {4'd8, 32'h00008234, 5'd1})
            $display("FAIL lui: got ctl=%0d imm=%h dst=%0d, need 8,00008234,1", alu_ctrl, imm, dst);
        else passed++;

        issue(32'hAC22FFFC);  // sw $2,-4($1)
        total++;
        if ({alu_ctrl, imm, src_imm, reg_write} !== {4'd2, 32'hFFFFFFFC, 1'b1, 1'b0})
            $display("FAIL sw: got ctl=%0d imm=%h src=%b rw=%b, need 2,fffffffc,1,0", alu_ctrl, imm, src_imm, reg_write);
        else passed++;
    endtask

    task automatic test_jump_branch();
        issue(32'h0C000010);  // jal
        total++;
        if ({alu_ctrl, dst, reg_write, src_imm} !== {4'd9, 5'd31, 1'b1, 1'b0})
            $display("FAIL jal: got ctl=%0d dst=%0d rw=%b src=%b, need 9,31,1,0", alu_ctrl, dst, reg_write, src_imm);
        else passed++;

        issue(32'h14220003);  // bne $1,$2,3
        total++;
        if ({alu_ctrl, reg_write, src_imm, imm} !== {4'd5, 1'b0, 1'b0, 32'h00000003})
            $display("FAIL bne: got ctl=%0d rw=%b src=%b imm=%h, need 5,0,0,00000003", alu_ctrl, reg_write, src_imm, imm);
        else passed++;

        issue(32'h1022FFFE);  // beq $1,$2,-2
        total++;
        if ({alu_ctrl, reg_write, imm} !== {4'd6, 1'b0, 32'hFFFFFFFE})
            $display("FAIL beq: got ctl=%0d rw=%b imm=%h, need 6,0,fffffffe", alu_ctrl, reg_write, imm);
        else passed++;
    endtask

    task automatic test_stall();
        issue(32'h00221820);
        instr = 32'h3422FFFF;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({vld, alu_ctrl, dst, src_imm} !== {1'b1, 4'd2, 5'd3, 1'b0})
                $display("FAIL stall_hold[%0d]: got v=%b ctl=%0d dst=%0d src=%b, need 1,2,3,0", c, vld, alu_ctrl, dst, src_imm);
            else passed++;
        end
        stall = 1'b0;
        step();
        total++;
        if ({alu_ctrl, dst, imm} !== {4'd1, 5'd2, 32'h0000FFFF})
            $display("FAIL stall_release: got ctl=%0d dst=%0d imm=%h, need 1,2,0000ffff", alu_ctrl, dst, imm);
        else passed++;
    endtask

    task automatic test_flush_illegal();
        issue(32'h00221820);
        stall = 1'b1;
        flush = 1'b1;
        step();
        total++;
        if ({vld, reg_write, alu_ctrl, dst} !== {1'b0, 1'b0, 4'd2, 5'd0})
            $display("FAIL flush_stall: got v=%b rw=%b ctl=%0d dst=%0d, need 0,0,2,0", vld, reg_write, alu_ctrl, dst);
        else passed++;

        issue(32'hFC221820);  // opcode 0x3F
        total++;
        if ({vld, illegal, reg_write, src_imm, alu_ctrl} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd2})
            $display("FAIL illegal_op: got v=%b ill=%b rw=%b src=%b ctl=%0d, need 1,1,0,0,2", vld, illegal, reg_write, src_imm, alu_ctrl);
        else passed++;

        issue(32'h00221801);  // R-type funct 0x01
        total++;
        if ({vld, illegal, reg_write} !== {1'b1, 1'b1, 1'b0})
            $display("FAIL illegal_funct: got v=%b ill=%b rw=%b, need 1,1,0", vld, illegal, reg_write);
        else passed++;

        instr  = 32'h00221820;
        vld_in = 1'b0;
        step();
        total++;
        if ({vld, reg_write, dst} !== {1'b0, 1'b0, 5'd0})
            $display("FAIL invalid_in: got v=%b rw=%b dst=%0d, need 0,0,0", vld, reg_write, dst);
        else passed++;
    endtask

    task automatic test_reset_mid();
        issue(32'h000521C0);
        stall = 1'b1;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        total++;
        if ({vld, alu_ctrl, shamt, imm, src_imm, reg_write, dst, illegal} !==
            {1'b0, 4'd2, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0})
            $display("FAIL reset_mid: got v=%b ctl=%0d sh=%0d imm=%h rw=%b dst=%0d, need 0,2,0,0,0,0",
                     vld, alu_ctrl, shamt, imm, reg_write, dst);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_jump_branch();
        test_stall();
        test_flush_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/d_alu_decode.md
Name: d_alu_decode

Overview:
Decode-stage ALU control generator with an integrated ID/EX pipeline register. It takes a 32-bit MIPS instruction from the IF/ID stage and produces the execute-stage ALU control code, shift amount, immediate operand, operand-B select and writeback destination, all registered with one-cycle latency. It honours the hazard unit's stall and flush requests. It is the producer side of the execute-stage ALU control interface: its registered outputs drive the ALU's control, shamt and B-operand mux directly.

Parameters:
DATA_W, 32, instruction and immediate width
REG_AW, 5, register-address width
LINK_REG, 31, destination register for jal

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_data_Instr  input  32  instruction from IF/ID
i_con_Valid  input  1  i_data_Instr holds a real instruction
i_con_Stall  input  1  hold ID/EX contents
i_con_Flush  input  1  replace next ID/EX contents with a bubble
o_con_Valid  output  1  ID/EX holds a real instruction
o_con_AluCtrl  output  4  ALU operation code
o_data_shamt  output  5  shift amount, instr[10:6]
o_data_Imm  output  32  extended immediate
o_con_AluSrcImm  output  1  ALU B operand = o_data_Imm
o_con_RegWrite  output  1  writeback enable
o_data_Dst  output  5  writeback register
o_con_Illegal  output  1  unsupported opcode or funct

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset values: Valid=0, AluCtrl=2, shamt=0, Imm=0, AluSrcImm=0, RegWrite=0, Dst=0, Illegal=0. Reset overrides stall and flush.
- Latency: combinational decode, captured on the next rising edge; 1 cycle total.
- Priority per edge: reset > flush > stall > load.
  - Flush, with or without stall: load the bubble (the reset values).
  - Stall without flush: all outputs hold.
  - Otherwise: load the decoded instruction. If i_con_Valid=0, load a bubble.
- AluCtrl codes: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 EQ, 6 SUB, 7 SLT, 8 LUI, 9 LINK, 12 NOR, 13 XOR, 14 PASSA.
- R-type (op=0x00), Dst=rd, RegWrite=1, AluSrcImm=0:
  - funct 0x20/0x21 → 2; 0x22/0x23 → 6; 0x24 → 0; 0x25 → 1; 0x26 → 13; 0x27 → 12; 0x2A/0x2B → 7.
  - funct 0x00 → 3; 0x02 → 4.
  - funct 0x08 (jr) → 14, RegWrite=0.
- I-type, Dst=rt, AluSrcImm=1:
  - addi 0x08 / addiu 0x09 → 2, sign-extend.
  - slti 0x0A / sltiu 0x0B → 7, sign-extend.
  - andi 0x0C → 0, ori 0x0D → 1, xori 0x0E → 13; all zero-extend.
  - lui 0x0F → 8, zero-extend.
  - lw 0x23 → 2, sign-extend, RegWrite=1.
  - sw 0x2B → 2, sign-extend, RegWrite=0.
- Branches, AluSrcImm=0, RegWrite=0, Imm sign-extended:
  - beq 0x04 → 6 (taken on zero flag).
  - bne 0x05 → 5 (taken on zero flag).
- Jumps:
  - j 0x02: AluCtrl=2, RegWrite=0.
  - jal 0x03: AluCtrl=9, Dst=LINK_REG, RegWrite=1, AluSrcImm=0.
- shamt always equals instr[10:6]; it is meaningful only for codes 3 and 4.
- Illegal opcode or funct: Valid=1, Illegal=1, AluCtrl=2, RegWrite=0, AluSrcImm=0.
- Dst=0 with RegWrite=1 is passed through unchanged; the register file ignores writes to register 0.

Decomposition:
- Shared package alu_pkg:
  - alu_ctrl_e enum holding the 4-bit codes above.
  - Opcode and funct localparams.
  - Bubble/reset constant of the ID/EX control struct.
- Sub-module d_alu_ctrl_dec: purely combinational instruction → control struct.
- The top level holds only the ID/EX register and the stall/flush priority logic.

Test Plan:
- Reset, then 0x00221820 (add $3,$1,$2) with Valid=1 → next cycle AluCtrl=2, Dst=3, RegWrite=1, AluSrcImm=0, Valid=1.
- 0x000521C0 (sll $4,$5,7) → AluCtrl=3, shamt=7, Dst=4. Then 0x3422FFFF (ori) → AluCtrl=1, Imm=0x0000FFFF, Dst=2. Then 0x2022FFFF (addi) → Imm=0xFFFFFFFF.
- 0x0C000010 (jal) → AluCtrl=9, Dst=31, RegWrite=1. Then 0x14220003 (bne) → AluCtrl=5, RegWrite=0, Imm=0x00000003.
- Load add; assert Stall for 3 cycles while presenting ori → outputs stay add for 3 cycles. Release stall → ori appears next cycle.
- Stall=1 and Flush=1 together → next cycle Valid=0, RegWrite=0, AluCtrl=2. Illegal opcode 0x3F → Valid=1, Illegal=1, RegWrite=0.
- Assert i_rst mid-stream during stall → outputs at reset values on the next edge.
